// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared sector, state and gate-pattern definitions for the BLDC commutator
package bldc_pkg;

   localparam logic [2:0] SEC_A          = 3'd0;
   localparam logic [2:0] SEC_B          = 3'd1;
   localparam logic [2:0] SEC_C          = 3'd2;
   localparam logic [2:0] SEC_D          = 3'd3;
   localparam logic [2:0] SEC_E          = 3'd4;
   localparam logic [2:0] SEC_F          = 3'd5;
   localparam logic [2:0] SECTOR_INVALID = 3'd7;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DEAD  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Bit order {HA,LA,HB,LB,HC,LC}
   typedef logic [5:0] gate_t;

   localparam gate_t HIGH_SIDES = 6'b101010;

   function automatic gate_t pattern(input logic [2:0] sector, input logic dir);
      gate_t p;
      p = '0;
      case (sector)
         SEC_A:   p = dir ? 6'b000110 : 6'b001001;
         SEC_B:   p = dir ? 6'b100100 : 6'b011000;
         SEC_C:   p = dir ? 6'b100001 : 6'b010010;
         SEC_D:   p = dir ? 6'b001001 : 6'b000110;
         SEC_E:   p = dir ? 6'b011000 : 6'b100100;
         SEC_F:   p = dir ? 6'b010010 : 6'b100001;
         default: p = '0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// rtl/bldc_commutator_if.sv - command, gate-drive and status bundle of the commutator
interface bldc_commutator_if;
   logic       enable;
   logic       dir;
   logic       pwm_in;
   logic [2:0] hall;
   logic       fault_n;
   logic       clear_fault;
   logic       inha;
   logic       inla;
   logic       inhb;
   logic       inlb;
   logic       inhc;
   logic       inlc;
   logic [2:0] sector;
   logic       hall_error;
   logic       fault_latched;
   logic [1:0] state_o;

   modport master (
      output enable, dir, pwm_in, hall, fault_n, clear_fault,
      input  inha, inla, inhb, inlb, inhc, inlc,
      input  sector, hall_error, fault_latched, state_o
   );

   modport slave (
      input  enable, dir, pwm_in, hall, fault_n, clear_fault,
      output inha, inla, inhb, inlb, inhc, inlc,
      output sector, hall_error, fault_latched, state_o
   );
endinterface

// File: rtl/hall_sector_decode.sv
// rtl/hall_sector_decode.sv - registered hall triple to sector decode with invalid-code flag
module hall_sector_decode
   import bldc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] hall,
   output logic [2:0] sector,
   output logic       hall_error
);

   logic [2:0] sector_d;
   logic       error_d;

   always_comb begin
      sector_d = SECTOR_INVALID;
      error_d  = 1'b0;
      case (hall)
         3'b101:  sector_d = SEC_A;
         3'b100:  sector_d = SEC_B;
         3'b110:  sector_d = SEC_C;
         3'b010:  sector_d = SEC_D;
         3'b011:  sector_d = SEC_E;
         3'b001:  sector_d = SEC_F;
         default: error_d  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sector     <= SECTOR_INVALID;
         hall_error <= 1'b0;
      end else begin
         sector     <= sector_d;
         hall_error <= error_d;
      end
   end

endmodule

// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step commutation FSM with dead-time, PWM gating and fault latch
module bldc_commutator
   import bldc_pkg::*;
#(
   parameter int DT_CYCLES = 1024,
   parameter int DT_W      = 11
) (
   input  logic clk,
   input  logic reset,
   bldc_commutator_if.slave bus
);

   localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT_CYCLES > 0 ? DT_CYCLES - 1 : 0);

   logic [2:0]      sector;
   logic            hall_error;
   logic            sector_valid;
   logic [3:0]      key;
   logic [3:0]      key_q, key_d;
   state_t          state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   gate_t           gate_q, gate_d;

   hall_sector_decode u_decode (
      .clk        (clk),
      .reset      (reset),
      .hall       (bus.hall),
      .sector     (sector),
      .hall_error (hall_error)
   );

   assign sector_valid = (sector != SECTOR_INVALID);
   assign key          = {sector, bus.dir};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      if (!bus.fault_n) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (bus.enable && sector_valid) begin
                  state_d = ST_DEAD;
                  cnt_d   = DT_LOAD;
                  key_d   = key;
               end
            end
            ST_DEAD: begin
               if (!bus.enable || !sector_valid) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (key != key_q) begin
                  // A new key restarts the full dead-time, even on the last count
                  cnt_d = DT_LOAD;
                  key_d = key;
               end else if (cnt_q == '0) begin
                  state_d = ST_DRIVE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_DRIVE: begin
               if (!bus.enable || !sector_valid) begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end else if (key != key_q) begin
                  state_d = ST_DEAD;
                  cnt_d   = DT_LOAD;
                  key_d   = key;
               end
            end
            ST_FAULT: begin
               if (bus.clear_fault) begin
                  state_d = ST_DEAD;
                  cnt_d   = DT_LOAD;
                  key_d   = key;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // Gates follow the next state so they drop on the same edge that leaves DRIVE
   always_comb begin
      gate_d = '0;
      if (state_d == ST_DRIVE) begin
         gate_d = pattern(sector, bus.dir) & (bus.pwm_in ? 6'b111111 : ~HIGH_SIDES);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         key_q   <= {SECTOR_INVALID, 1'b0};
         gate_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         gate_q  <= gate_d;
      end
   end

   assign bus.inha          = gate_q[5];
   assign bus.inla          = gate_q[4];
   assign bus.inhb          = gate_q[3];
   assign bus.inlb          = gate_q[2];
   assign bus.inhc          = gate_q[1];
   assign bus.inlc          = gate_q[0];
   assign bus.sector        = sector;
   assign bus.hall_error    = hall_error;
   assign bus.fault_latched = (state_q == ST_FAULT);
   assign bus.state_o       = state_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// tb/tb_bldc_commutator.sv - directed self-checking bench for bldc_commutator with DT_CYCLES=8
module tb_bldc_commutator;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   z0;
   int   z1;
   logic [5:0] pat;

   bldc_commutator_if bus();

   bldc_commutator #(.DT_CYCLES(8), .DT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {HA,LA,HB,LB,HC,LC}
   logic [5:0] fwd_pat [6] = '{6'b000110, 6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010};
   logic [2:0] hall_seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
   logic [5:0] rev_b = 6'b011000;

   function automatic logic [5:0] gates();
      return {bus.inha, bus.inla, bus.inhb, bus.inlb, bus.inhc, bus.inlc};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [5:0] g;
      int hi;
      int lo;
      @(negedge clk);
      g  = gates();
      hi = int'(g[5]) + int'(g[3]) + int'(g[1]);
      lo = int'(g[4]) + int'(g[2]) + int'(g[0]);
      chk("no_shoot_through", {29'd0, (g[5] & g[4]) | (g[3] & g[2]) | (g[1] & g[0]), hi > 1, lo > 1}, 32'd0);
   endtask

   // Counts DEAD samples with all gates off until a new non-zero pattern appears
   task automatic run_to_drive(input logic [5:0] old_pat, output int zeros, output logic [5:0] new_pat);
      logic [5:0] g;
      logic done;
      zeros   = 0;
      new_pat = '0;
      done    = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         tick();
         g = gates();
         if (g == 6'd0 && bus.state_o == 2'd1) begin
            zeros++;
         end else if (g != 6'd0 && (zeros > 0 || g != old_pat)) begin
            new_pat = g;
            done    = 1'b1;
         end
      end
      chk("drive_reached", {31'd0, done}, 32'd1);
   endtask

   initial begin
      bus.enable      = 1'b1;
      bus.dir         = 1'b1;
      bus.pwm_in      = 1'b1;
      bus.hall        = 3'b101;
      bus.fault_n     = 1'b1;
      bus.clear_fault = 1'b0;

      tick();
      tick();
      chk("reset_gates", {26'd0, gates()}, 32'd0);
      chk("reset_sector", {29'd0, bus.sector}, 32'd7);
      chk("reset_hall_error", {31'd0, bus.hall_error}, 32'd0);
      chk("reset_fault_latched", {31'd0, bus.fault_latched}, 32'd0);
      chk("reset_state", {30'd0, bus.state_o}, 32'd0);

      reset = 1'b0;
      run_to_drive(6'd0, z0, pat);
      chk("startup_dead_cycles", z0, 32'd8);
      chk("startup_pattern_A", {26'd0, pat}, {26'd0, fwd_pat[0]});
      chk("startup_state", {30'd0, bus.state_o}, 32'd2);
      chk("startup_sector", {29'd0, bus.sector}, 32'd0);

      for (int i = 1; i < 6; i++) begin
         bus.hall = hall_seq[i];
         run_to_drive(fwd_pat[i-1], z0, pat);
         chk("sweep_dead_cycles", z0, 32'd8);
         chk("sweep_pattern", {26'd0, pat}, {26'd0, fwd_pat[i]});
         repeat (90) tick();
         chk("sweep_hold", {26'd0, gates()}, {26'd0, fwd_pat[i]});
      end

      bus.hall = 3'b100;
      run_to_drive(fwd_pat[5], z0, pat);
      chk("to_B_pattern", {26'd0, pat}, {26'd0, fwd_pat[1]});

      bus.dir = 1'b0;
      run_to_drive(fwd_pat[1], z0, pat);
      chk("dir_dead_cycles", z0, 32'd8);
      chk("dir_reverse_B", {26'd0, pat}, {26'd0, rev_b});

      bus.dir = 1'b1;
      z0 = 0;
      tick();
      if (bus.state_o == 2'd1 && gates() == 6'd0) z0++;
      tick();
      if (bus.state_o == 2'd1 && gates() == 6'd0) z0++;
      bus.hall = 3'b110;
      run_to_drive(rev_b, z1, pat);
      chk("restart_total_dead", z0 + z1, 32'd11);
      chk("restart_pattern_C", {26'd0, pat}, {26'd0, fwd_pat[2]});

      bus.hall = 3'b111;
      tick();
      chk("invalid_decode_sector", {29'd0, bus.sector}, 32'd7);
      chk("invalid_decode_error", {31'd0, bus.hall_error}, 32'd1);
      tick();
      chk("invalid_state_off", {30'd0, bus.state_o}, 32'd0);
      chk("invalid_gates_off", {26'd0, gates()}, 32'd0);
      chk("invalid_error_held", {31'd0, bus.hall_error}, 32'd1);
      bus.hall = 3'b010;
      run_to_drive(6'd0, z0, pat);
      chk("recover_dead_cycles", z0, 32'd8);
      chk("recover_pattern_D", {26'd0, pat}, {26'd0, fwd_pat[3]});
      chk("recover_error_clear", {31'd0, bus.hall_error}, 32'd0);

      bus.fault_n = 1'b0;
      tick();
      bus.fault_n = 1'b1;
      chk("fault_state", {30'd0, bus.state_o}, 32'd3);
      chk("fault_latched", {31'd0, bus.fault_latched}, 32'd1);
      chk("fault_gates_off", {26'd0, gates()}, 32'd0);
      repeat (3) tick();
      chk("fault_sticky", {30'd0, bus.state_o}, 32'd3);
      bus.fault_n     = 1'b0;
      bus.clear_fault = 1'b1;
      tick();
      chk("fault_clear_blocked", {30'd0, bus.state_o}, 32'd3);
      bus.fault_n = 1'b1;
      run_to_drive(6'd0, z0, pat);
      bus.clear_fault = 1'b0;
      chk("fault_exit_dead_cycles", z0, 32'd8);
      chk("fault_exit_pattern_D", {26'd0, pat}, {26'd0, fwd_pat[3]});
      chk("fault_latched_cleared", {31'd0, bus.fault_latched}, 32'd0);

      bus.hall = 3'b110;
      run_to_drive(fwd_pat[3], z0, pat);
      chk("pwm_setup_pattern_C", {26'd0, pat}, {26'd0, fwd_pat[2]});
      for (int k = 0; k < 24; k++) begin
         bus.pwm_in = ((k / 4) % 2) == 1;
         z1 = int'(bus.pwm_in);
         tick();
         chk("pwm_inha_follows", {31'd0, bus.inha}, z1);
         chk("pwm_inlc_static", {31'd0, bus.inlc}, 32'd1);
      end

      bus.pwm_in = 1'b1;
      tick();
      chk("pre_reset_inha", {31'd0, bus.inha}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_gates", {26'd0, gates()}, 32'd0);
      chk("async_reset_state", {30'd0, bus.state_o}, 32'd0);
      chk("async_reset_sector", {29'd0, bus.sector}, 32'd7);
      tick();
      reset = 1'b0;
      tick();
      chk("post_reset_gates", {26'd0, gates()}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
